// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown timer with prescaler, load and saturating add
module bcd_down_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                add_en,
    input  logic [4*DIGITS-1:0] add_val,
    input  logic                run,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                expired,
    output logic                tick
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRES_MAX = PW'(TICK_DIV - 1);

    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] pres_q, pres_d;
    logic          tick_q, tick_d;
    logic          pending_q, pending_d;
    logic          expired_q, expired_d;

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Carry out of the top digit saturates the whole value to all nines.
    function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic [4:0]   s_adj;
        logic         carry;
        r     = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s     = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
            s_adj = s - 5'd10;
            if (s > 5'd9) begin
                r[4*i +: 4] = s_adj[3:0];
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                carry       = 1'b0;
            end
        end
        if (carry) begin
            r = {DIGITS{4'h9}};
        end
        return r;
    endfunction

    always_comb begin
        count_d   = count_q;
        pres_d    = pres_q;
        tick_d    = 1'b0;
        pending_d = pending_q;
        expired_d = 1'b0;

        if (run) begin
            if (pres_q == PRES_MAX) begin
                pres_d = '0;
                tick_d = 1'b1;
            end else begin
                pres_d = pres_q + PW'(1);
            end
        end

        if (load) begin
            count_d   = load_val;
            pending_d = 1'b0;
            pres_d    = '0;
            tick_d    = 1'b0;
        end else if (add_en) begin
            count_d = bcd_add_sat(count_q, add_val);
            if (tick_q) begin
                pending_d = 1'b1;
            end
        end else if (tick_q || pending_q) begin
            // A tick at zero is consumed without wrapping.
            pending_d = 1'b0;
            if (count_q != '0) begin
                count_d   = bcd_dec(count_q);
                expired_d = (count_q == W'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            pres_q    <= '0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pres_q    <= pres_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign zero    = (count_q == '0);
    assign expired = expired_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - directed self-checking bench for bcd_down_counter
module tb_bcd_down_counter;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        add_en;
    logic [15:0] add_val;
    logic        run;
    logic [15:0] count;
    logic        zero;
    logic        expired;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int pulses;

    bcd_down_counter #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .add_en   (add_en),
        .add_val  (add_val),
        .run      (run),
        .count    (count),
        .zero     (zero),
        .expired  (expired),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_seq [5];
        exp_seq[0] = 16'h0103;
        exp_seq[1] = 16'h0102;
        exp_seq[2] = 16'h0101;
        exp_seq[3] = 16'h0100;
        exp_seq[4] = 16'h0099;

        rst = 1'b1; load = 1'b0; load_val = '0; add_en = 1'b0; add_val = '0; run = 1'b0;
        step(2);
        check("rst_count", 32'(count), 32'h0);
        check("rst_zero", 32'(zero), 32'h1);
        check("rst_expired", 32'(expired), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        rst = 1'b0;

        // Countdown from 0105 with borrow across two digits
        load = 1'b1; load_val = 16'h0105; run = 1'b1;
        step(1);
        load = 1'b0;
        check("load_0105", 32'(count), 32'h0105);
        step(4);
        check("tick_first", 32'(tick), 32'h1);
        check("cnt_before_dec", 32'(count), 32'h0105);
        step(1);
        check("dec_0104", 32'(count), 32'h0104);
        check("tick_low", 32'(tick), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(4);
            check($sformatf("dec_seq%0d", i), 32'(count), 32'(exp_seq[i]));
        end

        // Expiry from 0002
        load = 1'b1; load_val = 16'h0002;
        step(1);
        load = 1'b0;
        check("load_0002", 32'(count), 32'h0002);
        step(5);
        check("dec_0001", 32'(count), 32'h0001);
        check("no_exp_0001", 32'(expired), 32'h0);
        step(4);
        check("dec_0000", 32'(count), 32'h0000);
        check("zero_rise", 32'(zero), 32'h1);
        check("expired_pulse", 32'(expired), 32'h1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (expired) pulses++;
        end
        check("no_more_expired", 32'(pulses), 32'h0);
        check("stay_zero", 32'(count), 32'h0000);

        // Saturating and carrying adds with the prescaler frozen
        load = 1'b1; load_val = 16'h9990; run = 1'b0;
        step(1);
        load = 1'b0; add_en = 1'b1; add_val = 16'h0025;
        step(1);
        add_en = 1'b0;
        check("add_sat", 32'(count), 32'h9999);
        load = 1'b1; load_val = 16'h0123;
        step(1);
        load = 1'b0; add_en = 1'b1; add_val = 16'h0877;
        step(1);
        add_en = 1'b0;
        check("add_carry", 32'(count), 32'h1000);

        // Add coincident with tick defers the decrement by one cycle
        load = 1'b1; load_val = 16'h0050; run = 1'b1;
        step(1);
        load = 1'b0;
        step(4);
        check("tick_for_add", 32'(tick), 32'h1);
        add_en = 1'b1; add_val = 16'h0010;
        step(1);
        add_en = 1'b0;
        check("add_with_tick", 32'(count), 32'h0060);
        step(1);
        check("deferred_dec", 32'(count), 32'h0059);

        // Freeze for 10 cycles with prescaler at 2, then resume
        run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (tick) pulses++;
        end
        check("frozen_ticks", 32'(pulses), 32'h0);
        check("frozen_count", 32'(count), 32'h0059);
        run = 1'b1;
        step(1);
        check("resume_no_tick", 32'(tick), 32'h0);
        step(1);
        check("resume_tick", 32'(tick), 32'h1);
        step(1);
        check("resume_dec", 32'(count), 32'h0058);

        // Load while frozen
        run = 1'b0; load = 1'b1; load_val = 16'h0042;
        step(1);
        load = 1'b0;
        check("load_frozen", 32'(count), 32'h0042);

        // Asynchronous reset between edges
        run = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'h0);
        check("arst_zero", 32'(zero), 32'h1);
        check("arst_expired", 32'(expired), 32'h0);
        step(2);
        rst = 1'b0;
        step(3);
        check("post_rst_no_tick", 32'(tick), 32'h0);
        step(1);
        check("post_rst_tick", 32'(tick), 32'h1);
        check("post_rst_expired", 32'(expired), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Parametrised multi-digit BCD countdown timer with load, saturating BCD add and a built-in prescaler. It generalises the single-purpose decrementer to a configurable digit count and tick rate, adds add-time and terminal-count events, and drives the seven-segment display path directly with packed BCD.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits (1-8); count width is 4*DIGITS.
- TICK_DIV, 100000000, clock cycles per decrement tick (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  load count from load_val; also clears prescaler and pending tick.
- load_val  in  4*DIGITS  packed BCD load value; each nibble must be 0-9.
- add_en  in  1  add add_val to count, saturating.
- add_val  in  4*DIGITS  packed BCD addend; each nibble must be 0-9.
- run  in  1  1 = prescaler advances and ticks decrement; 0 = frozen.
- count  out  4*DIGITS  current packed BCD value, digit 0 in bits [3:0].
- zero  out  1  high while count == 0.
- expired  out  1  one-cycle pulse when a decrement takes count from 1 to 0.
- tick  out  1  one-cycle pulse on each prescaler terminal count.

## Operation

- Reset values: count = 0, zero = 1, expired = 0, tick = 0, prescaler = 0, pending = 0.
- Prescaler: while run = 1, increments each cycle; on reaching TICK_DIV-1 wraps to 0 and asserts tick for that cycle. Holds its value while run = 0. Cleared by load.
- Priority per cycle: load > add_en > decrement.
- load: count <= load_val; pending <= 0; expired not asserted even if load_val = 0.
- add_en (no load): count <= min(count + add_val, all nines), digit-wise BCD add with carry; carry out of top digit forces every digit to 9. If a tick occurs in the same cycle, it sets pending = 1.
- Decrement: occurs on a cycle with no load/add_en where (tick = 1 or pending = 1) and count != 0; pending cleared. BCD decrement: lowest digit -1; a digit at 0 becomes 9 and borrows from the next.
- Count == 0 on a tick: no change, no wrap, pending cleared, no expired.
- expired: asserted in the cycle after the decrement registers count 1 -> 0 (registered with count).
- zero: combinational compare of registered count.
- Pending holds at most one tick; a second tick while pending still set and add_en held is dropped.
- run = 0 does not block load or add_en; a pending tick is still applied when run = 0.
- Invalid BCD inputs (nibble > 9): undefined result; verification constrains stimulus.

## Timing

- Load, add and decrement results visible on count one cycle after the qualifying edge.
- tick is registered: high for exactly one cycle every TICK_DIV cycles of run = 1.
- Tick coincident with add_en: add applied at edge N, deferred decrement applied at edge N+1 if add_en low then.
- Asynchronous rst mid-operation: all state immediately to reset values; first tick after release is TICK_DIV cycles of run later.
- Expiry latency: expired and zero rise together in the cycle after the final tick.

## Test plan

- Reset then load 0x0105 (DIGITS=4, TICK_DIV=4, run=1) -> count 0104, 0103, 0102, 0101, 0100, 0099 at 4-cycle spacing (borrow across two digits).
- Load 0x0002, run -> count 0001 then 0000; expired single pulse coinciding with zero rising; further ticks leave 0000, no expired.
- Count 9990, add_en with add_val 0x0025 -> count 9999 (saturated); count 0123 + 0x0877 -> 1000.
- add_en asserted on the same cycle as tick with count 0050 + 0x0010 -> 0060 next cycle, 0059 the cycle after.
- run toggled low for 10 cycles mid-period -> tick and count frozen, resume with remaining prescaler count; load during run=0 takes effect next cycle.
- Assert rst asynchronously between edges while count = 0042 -> count 0000, zero 1 immediately, no expired pulse.
